// File: rtl/alu_biquad_stereo.sv
// Stereo direct-form-I biquad sequencer. Acts as Wishbone master of the ALU
// in DSP mode and runs five multiply-accumulate steps per stereo sample,
// with the left and right channels processed in parallel.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | ready for a sample; clear_state zeroes the filter history
//   REQ    | strobe asserted for step k, held while the ALU stalls
//   WAIT   | cycle held, waiting for ack; the down-counter bounds the wait
//   OUT    | one-cycle result strobe, then back to IDLE
module alu_biquad_stereo #(
  parameter int         COEF_FRAC   = 16,
  parameter logic [7:0] OP_MAC      = 8'h01,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_state,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [17:0] in_xl,
  input  logic signed [17:0] in_xr,
  input  logic signed [17:0] coef_b0,
  input  logic signed [17:0] coef_b1,
  input  logic signed [17:0] coef_b2,
  input  logic signed [17:0] coef_a1,
  input  logic signed [17:0] coef_a2,
  output logic               out_valid,
  output logic signed [17:0] out_yl,
  output logic signed [17:0] out_yr,
  output logic               err,
  output logic               alu_cycle,
  output logic               alu_strobe,
  input  logic               alu_ack,
  input  logic               alu_stall,
  output logic               alu_mode,
  output logic [7:0]         alu_op,
  output logic signed [17:0] alu_al,
  output logic signed [17:0] alu_bl,
  output logic signed [17:0] alu_ar,
  output logic signed [17:0] alu_br,
  output logic signed [47:0] alu_cl,
  output logic signed [47:0] alu_cr,
  input  logic signed [47:0] alu_pl,
  input  logic signed [47:0] alu_pr
);

  localparam logic ALU_MODE_DSP = 1'b1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  // Loaded on entry to WAIT; terminal count at zero gives ACK_TIMEOUT WAIT cycles.
  localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 1);

  localparam logic signed [17:0] S18_MAX = 18'sh1FFFF;
  localparam logic signed [17:0] S18_MIN = 18'sh20000;

  logic [1:0]    state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;

  logic signed [17:0] x_l_q, x_r_q;
  logic signed [17:0] b0_q, b1_q, b2_q, a1_q, a2_q;
  logic signed [17:0] x1_l_q, x2_l_q, y1_l_q, y2_l_q;
  logic signed [17:0] x1_r_q, x2_r_q, y1_r_q, y2_r_q;
  logic signed [47:0] acc_l_q, acc_r_q;
  logic signed [17:0] out_yl_q, out_yr_q;

  logic accept, do_clear, ack_take, finish, in_txn;
  logic signed [17:0] y_l, y_r;

  // Negation with the single unrepresentable case clamped.
  function automatic logic signed [17:0] neg_sat(input logic signed [17:0] v);
    if (v == S18_MIN) return S18_MAX;
    return -v;
  endfunction

  // Drop the coefficient fraction and clamp back to an 18-bit sample.
  function automatic logic signed [17:0] scale_sat(input logic signed [47:0] p);
    logic signed [47:0] s;
    s = p >>> COEF_FRAC;
    if (s > 48'sd131071)  return S18_MAX;
    if (s < -48'sd131072) return S18_MIN;
    return s[17:0];
  endfunction

  assign accept   = (state_q == S_IDLE) && !clear_state && in_valid;
  assign do_clear = (state_q == S_IDLE) && clear_state;
  assign ack_take = (state_q == S_WAIT) && alu_ack;
  assign finish   = ack_take && (k_q == 3'd4);
  assign in_txn   = (state_q == S_REQ) || (state_q == S_WAIT);

  assign y_l = scale_sat(alu_pl);
  assign y_r = scale_sat(alu_pr);

  // Sequencer next-state: step progression, stall hold and ack timeout.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tmr_d   = tmr_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
          k_d     = 3'd0;
        end
      end
      S_REQ: begin
        if (!alu_stall) begin
          state_d = S_WAIT;
          tmr_d   = TMR_LOAD;
        end
      end
      S_WAIT: begin
        if (alu_ack) begin
          if (k_q == 3'd4) begin
            state_d = S_OUT;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = S_REQ;
          end
        end else if (tmr_q == '0) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
    end
  end

  // Sample/coefficient latches, accumulators, history and result registers.
  // History moves only when the fifth step completes, so an aborted sample
  // leaves it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_l_q    <= '0;
      x_r_q    <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      x1_l_q   <= '0;
      x2_l_q   <= '0;
      y1_l_q   <= '0;
      y2_l_q   <= '0;
      x1_r_q   <= '0;
      x2_r_q   <= '0;
      y1_r_q   <= '0;
      y2_r_q   <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      out_yl_q <= '0;
      out_yr_q <= '0;
    end else begin
      if (accept) begin
        x_l_q <= in_xl;
        x_r_q <= in_xr;
        b0_q  <= coef_b0;
        b1_q  <= coef_b1;
        b2_q  <= coef_b2;
        a1_q  <= coef_a1;
        a2_q  <= coef_a2;
      end
      if (do_clear) begin
        x1_l_q <= '0;
        x2_l_q <= '0;
        y1_l_q <= '0;
        y2_l_q <= '0;
        x1_r_q <= '0;
        x2_r_q <= '0;
        y1_r_q <= '0;
        y2_r_q <= '0;
      end
      if (ack_take) begin
        acc_l_q <= alu_pl;
        acc_r_q <= alu_pr;
      end
      if (finish) begin
        out_yl_q <= y_l;
        out_yr_q <= y_r;
        x2_l_q   <= x1_l_q;
        x1_l_q   <= x_l_q;
        y2_l_q   <= y1_l_q;
        y1_l_q   <= y_l;
        x2_r_q   <= x1_r_q;
        x1_r_q   <= x_r_q;
        y2_r_q   <= y1_r_q;
        y1_r_q   <= y_r;
      end
    end
  end

  // Step operand mux; everything is zero outside a bus cycle.
  always_comb begin
    alu_al = '0;
    alu_bl = '0;
    alu_ar = '0;
    alu_br = '0;
    alu_cl = '0;
    alu_cr = '0;
    if (in_txn) begin
      case (k_q)
        3'd0: begin
          alu_al = b0_q;  alu_bl = x_l_q;
          alu_ar = b0_q;  alu_br = x_r_q;
        end
        3'd1: begin
          alu_al = b1_q;  alu_bl = x1_l_q;  alu_cl = acc_l_q;
          alu_ar = b1_q;  alu_br = x1_r_q;  alu_cr = acc_r_q;
        end
        3'd2: begin
          alu_al = b2_q;  alu_bl = x2_l_q;  alu_cl = acc_l_q;
          alu_ar = b2_q;  alu_br = x2_r_q;  alu_cr = acc_r_q;
        end
        3'd3: begin
          alu_al = neg_sat(a1_q);  alu_bl = y1_l_q;  alu_cl = acc_l_q;
          alu_ar = neg_sat(a1_q);  alu_br = y1_r_q;  alu_cr = acc_r_q;
        end
        3'd4: begin
          alu_al = neg_sat(a2_q);  alu_bl = y2_l_q;  alu_cl = acc_l_q;
          alu_ar = neg_sat(a2_q);  alu_br = y2_r_q;  alu_cr = acc_r_q;
        end
        default: begin
          alu_al = '0;
          alu_ar = '0;
        end
      endcase
    end
  end

  // Bus and handshake outputs decoded from state. Reset also gates in_ready
  // so every output except the mode bit reads zero while reset is held.
  assign alu_cycle  = in_txn;
  assign alu_strobe = (state_q == S_REQ);
  assign alu_mode   = ALU_MODE_DSP;
  assign alu_op     = in_txn ? OP_MAC : 8'h00;
  assign in_ready   = (state_q == S_IDLE) && !clear_state && !reset;
  assign out_valid  = (state_q == S_OUT);
  assign out_yl     = out_yl_q;
  assign out_yr     = out_yr_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_biquad_stereo.sv
// Testbench for alu_biquad_stereo: a behavioural ALU responder plus a
// biquad reference model computed directly from the filter equation.
module tb_alu_biquad_stereo;

  logic               clk = 1'b0;
  logic               reset;
  logic               clear_state;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] in_xl, in_xr;
  logic signed [17:0] coef_b0, coef_b1, coef_b2, coef_a1, coef_a2;
  logic               out_valid;
  logic signed [17:0] out_yl, out_yr;
  logic               err;
  logic               alu_cycle, alu_strobe;
  logic               alu_ack, alu_stall;
  logic               alu_mode;
  logic [7:0]         alu_op;
  logic signed [17:0] alu_al, alu_bl, alu_ar, alu_br;
  logic signed [47:0] alu_cl, alu_cr;
  logic signed [47:0] alu_pl, alu_pr;

  alu_biquad_stereo dut (
    .clk(clk), .reset(reset), .clear_state(clear_state),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_xl(in_xl), .in_xr(in_xr),
    .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_b2(coef_b2),
    .coef_a1(coef_a1), .coef_a2(coef_a2),
    .out_valid(out_valid), .out_yl(out_yl), .out_yr(out_yr), .err(err),
    .alu_cycle(alu_cycle), .alu_strobe(alu_strobe),
    .alu_ack(alu_ack), .alu_stall(alu_stall),
    .alu_mode(alu_mode), .alu_op(alu_op),
    .alu_al(alu_al), .alu_bl(alu_bl), .alu_ar(alu_ar), .alu_br(alu_br),
    .alu_cl(alu_cl), .alu_cr(alu_cr),
    .alu_pl(alu_pl), .alu_pr(alu_pr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_stb_cyc = 0;
  int n_err = 0;
  int n_ov = 0;
  int suppress_at = -1;

  // Reference model state.
  int cb0, cb1, cb2, ca1, ca2;
  int hx1[2], hx2[2], hy1[2], hy2[2];

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sneg(input int v);
    return (v == -131072) ? 131071 : -v;
  endfunction

  function automatic int ref_y(input int ch, input int x);
    longint acc, y;
    acc = longint'(cb0) * x + longint'(cb1) * hx1[ch] + longint'(cb2) * hx2[ch]
        + longint'(sneg(ca1)) * hy1[ch] + longint'(sneg(ca2)) * hy2[ch];
    y = acc >>> 16;
    if (y > 131071) y = 131071;
    if (y < -131072) y = -131072;
    return int'(y);
  endfunction

  function automatic void ref_push(input int ch, input int x, input int y);
    hx2[ch] = hx1[ch]; hx1[ch] = x;
    hy2[ch] = hy1[ch]; hy1[ch] = y;
  endfunction

  function automatic void ref_clear();
    for (int c = 0; c < 2; c++) begin
      hx1[c] = 0; hx2[c] = 0; hy1[c] = 0; hy2[c] = 0;
    end
  endfunction

  function automatic int rnd18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic set_coefs(input int b0, input int b1, input int b2,
                           input int a1, input int a2);
    cb0 = b0; cb1 = b1; cb2 = b2; ca1 = a1; ca2 = a2;
  endtask

  // Cycle counter and activity monitors.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (alu_strobe) n_stb_cyc++;
    if (err) n_err++;
    if (out_valid) n_ov++;
  end

  // ALU responder: P = A*B + C, ack three cycles after the accepted strobe.
  initial begin
    longint pl_v, pr_v;
    bit skip;
    alu_ack = 1'b0;
    alu_pl  = '0;
    alu_pr  = '0;
    forever begin
      @(negedge clk);
      if (!reset && alu_cycle && alu_strobe && !alu_stall) begin
        pl_v = longint'(alu_al) * longint'(alu_bl) + longint'(alu_cl);
        pr_v = longint'(alu_ar) * longint'(alu_br) + longint'(alu_cr);
        n_acc++;
        skip = (n_acc == suppress_at);
        repeat (3) @(posedge clk);
        #1;
        if (!skip) begin
          alu_ack = 1'b1;
          alu_pl  = pl_v[47:0];
          alu_pr  = pr_v[47:0];
        end
        @(posedge clk);
        #1;
        alu_ack = 1'b0;
        alu_pl  = '0;
        alu_pr  = '0;
      end
    end
  end

  // One full sample through the filter; called one time unit after a rising edge.
  task automatic run_sample(input int xl, input int xr, input int stall_n);
    int exl, exr, c0, stb0, acc0;
    bit seen;
    exl = ref_y(0, xl);
    exr = ref_y(1, xr);
    in_xl = 18'(xl); in_xr = 18'(xr);
    coef_b0 = 18'(cb0); coef_b1 = 18'(cb1); coef_b2 = 18'(cb2);
    coef_a1 = 18'(ca1); coef_a2 = 18'(ca2);
    in_valid  = 1'b1;
    alu_stall = (stall_n > 0);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    c0 = cyc; stb0 = n_stb_cyc; acc0 = n_acc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (stall_n > 0) begin
      repeat (stall_n) @(posedge clk);
      #1;
      alu_stall = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("out_valid_seen", seen, 1);
    if (seen) begin
      chk("latency", cyc - c0, 21 + stall_n);
      chk("out_yl", out_yl, exl);
      chk("out_yr", out_yr, exr);
      chk("strobes_accepted", n_acc - acc0, 5);
      chk("strobe_cycles", n_stb_cyc - stb0, 5 + stall_n);
      @(negedge clk);
      chk("out_valid_single", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
      chk("out_yl_hold", out_yl, exl);
    end
    ref_push(0, xl, exl);
    ref_push(1, xr, exr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, ov0, stb0;
    bit seen;
    reset = 1'b1; clear_state = 1'b0; in_valid = 1'b0; alu_stall = 1'b0;
    in_xl = '0; in_xr = '0;
    coef_b0 = '0; coef_b1 = '0; coef_b2 = '0; coef_a1 = '0; coef_a2 = '0;
    ref_clear();
    set_coefs(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_cycle", alu_cycle, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_mode", alu_mode, 1);
    chk("rst_out_yl", out_yl, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Passthrough
    set_coefs(65536, 0, 0, 0, 0);
    run_sample(1000, -1000, 0);

    // clear_state together with in_valid: nothing accepted, history zeroed
    clear_state = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear_state = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_no_accept", alu_cycle, 0);
    ref_clear();
    @(posedge clk);
    #1;

    // Recursion from zero history
    set_coefs(65536, 0, 0, -32768, 0);
    run_sample(16384, 16384, 0);
    chk("recur_y0", hy1[0], 16384);
    run_sample(0, 0, 0);
    chk("recur_y1", hy1[1], 8192);
    run_sample(0, 0, 0);
    chk("recur_y2", hy1[0], 4096);

    // Saturation, including neg(-131072)
    set_coefs(131071, 0, 0, 0, 0);
    run_sample(131071, -131072, 0);
    run_sample(-131072, 131071, 0);
    set_coefs(0, 0, 0, -131072, 0);
    run_sample(0, 0, 0);

    // Stall during k0
    set_coefs(65536, 0, 0, 0, 0);
    run_sample(1000, -1000, 5);

    // Ack timeout on k2
    set_coefs(30000, -20000, 10000, 5000, -3000);
    suppress_at = n_acc + 3;
    in_xl = 18'sd777; in_xr = -18'sd555;
    coef_b0 = 18'(cb0); coef_b1 = 18'(cb1); coef_b2 = 18'(cb2);
    coef_a1 = 18'(ca1); coef_a2 = 18'(ca2);
    in_valid = 1'b1;
    @(negedge clk);
    c0 = cyc; ov0 = n_ov;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (err) seen = 1'b1;
    end
    chk("timeout_err_seen", seen, 1);
    if (seen) begin
      chk("timeout_cycle", cyc - c0, 25);
      chk("timeout_cycle_drop", alu_cycle, 0);
      chk("timeout_in_ready", in_ready, 1);
      @(negedge clk);
      chk("timeout_err_pulse", err, 0);
    end
    chk("timeout_no_out", n_ov - ov0, 0);
    suppress_at = -1;
    repeat (6) @(posedge clk);
    #1;
    // History untouched by the aborted sample
    run_sample(4321, -1234, 0);

    // Reset during k3
    in_xl = 18'sd100; in_xr = 18'sd200;
    in_valid = 1'b1;
    @(negedge clk);
    c0 = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && (cyc - c0) < 13; i++) @(negedge clk);
    chk("k3_req_strobe", alu_strobe, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_cycle", alu_cycle, 0);
    chk("async_rst_strobe", alu_strobe, 0);
    chk("async_rst_op", alu_op, 0);
    chk("async_rst_al", alu_al, 0);
    chk("async_rst_cl", alu_cl, 0);
    chk("async_rst_out_yl", out_yl, 0);
    chk("async_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ref_clear();
    repeat (8) @(posedge clk);
    #1;

    // Randomized samples and coefficients
    for (int n = 0; n < 16; n++) begin
      if (n[0])
        set_coefs(rnd18(), rnd18(), rnd18(), rnd18(), rnd18());
      else
        set_coefs(int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 32767)) - 16384,
                  int'($urandom_range(0, 32767)) - 16384,
                  int'($urandom_range(0, 32767)) - 16384,
                  int'($urandom_range(0, 16383)) - 8192);
      run_sample(rnd18(), rnd18(), int'($urandom_range(0, 3)));
    end

    stb0 = n_err;
    chk("err_total", stb0, 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/alu_biquad_stereo.md
Name: alu_biquad_stereo

Overview:
- Stereo direct-form-I biquad sequencer that sits directly upstream of the ALU top and acts as its Wishbone master.
- Runs every multiply-accumulate in ALU DSP mode, left and right channels in parallel.
- Accepts one stereo sample per valid/ready handshake and returns one filtered stereo sample as a single-cycle out_valid pulse.
- Holds filter history (x1, x2, y1, y2 per channel) internally.

Parameters:
- COEF_FRAC, 16, fractional bits of the coefficients (Q2.16); samples are Q1.17.
- OP_MAC, 8'h01, ALU DSP opcode for P = A*B + C.
- ACK_TIMEOUT, 15, maximum WAIT cycles before a transaction aborts.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear_state  in  1  zero all filter history (honoured in IDLE only)
- in_valid  in  1  input sample valid
- in_ready  out  1  block idle and able to accept a sample
- in_xl, in_xr  in  18  signed input samples
- coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  in  18 each  signed Q2.16 coefficients, shared by both channels, sampled at acceptance
- out_valid  out  1  one-cycle result strobe
- out_yl, out_yr  out  18  signed saturated results
- err  out  1  one-cycle pulse on ack timeout
- alu_cycle, alu_strobe  out  1  Wishbone master CYC/STB
- alu_ack, alu_stall  in  1  Wishbone ACK/STALL
- alu_mode  out  1  always `ALU_MODE_DSP
- alu_op  out  8  OP_MAC during a transaction, else 0
- alu_al, alu_bl, alu_ar, alu_br  out  18  multiplier operands
- alu_cl, alu_cr  out  48  accumulator inputs
- alu_pl, alu_pr  in  48  ALU results, valid while alu_ack is high

Behaviour:
- Reset: all outputs 0 except alu_mode; all history, accumulators and coefficient latches cleared; FSM in IDLE.
- A reset mid-transaction drops alu_cycle immediately (asynchronous) and discards the sample.
- FSM states: IDLE, REQ, WAIT, OUT. Step counter k runs 0..4.
- IDLE:
  - in_ready = 1.
  - in_valid: latch x and the coefficients, k = 0, go to REQ.
  - clear_state takes priority over in_valid in the same cycle: history is zeroed, in_ready = 0 that cycle, no sample is accepted.
- REQ:
  - alu_cycle = alu_strobe = 1.
  - If alu_stall = 0: go to WAIT and reset the timeout counter. Otherwise stay in REQ with strobe held.
- WAIT:
  - alu_cycle = 1, alu_strobe = 0.
  - On alu_ack: acc <= alu_p. If k < 4: k++ and go to REQ. If k = 4: go to OUT.
  - Counter reaches ACK_TIMEOUT without ack: drop cycle, pulse err, return to IDLE with history unchanged and no out_valid.
- Operands stay stable for the whole cycle; outside a cycle all ALU outputs are 0.
- Step operands (A, B, C):
  - k0: b0, x, 0
  - k1: b1, x1, acc
  - k2: b2, x2, acc
  - k3: neg(a1), y1, acc
  - k4: neg(a2), y2, acc
- neg(v): two's-complement negate, with -131072 saturating to 131071.
- OUT:
  - y = acc >>> COEF_FRAC (arithmetic shift), saturated to [-131072, 131071].
  - out_valid = 1 for one cycle with out_yl/out_yr = y; outputs hold until the next OUT.
  - History update: x2 <= x1, x1 <= x, y2 <= y1, y1 <= y (saturated value).
  - Return to IDLE.
- Latency, with zero stall and an ALU ack 3 cycles after the accepted strobe: the acceptance cycle is cycle 0, step k REQ is at cycle 1+4k, out_valid is at cycle 21, in_ready returns at cycle 22.
- Each stall cycle adds one cycle to the latency.
- clear_state outside IDLE is ignored.
- alu_ack outside WAIT is ignored.

Test Plan:
- Passthrough: b0=65536, other coefs 0; x=(1000, -1000) → out_valid at cycle 21, y=(1000, -1000); exactly 5 strobes observed.
- Recursion: b0=65536, a1=-32768; x=16384, 0, 0 → y=16384, 8192, 4096 on both channels; history carries across samples.
- Saturation: b0=131071; x=131071 → y=131071. x=-131072 → y=-131072. a1=-131072 uses neg = 131071.
- Stall: alu_stall high for 5 cycles during k0 REQ → strobe held for 6 cycles; out_valid at cycle 26; result unchanged.
- Timeout/reset: ack suppressed at k2 → err pulse after 15 WAIT cycles, no out_valid, in_ready returns high, history unchanged. Reset asserted at k3 → all outputs 0 and alu_cycle low without waiting for a clock edge.
- clear_state with in_valid in IDLE: no accept. Next sample with a1=-32768 behaves as from zero history.
